// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// Each granted access takes three cycles: grant/latch, memory access, response.
`timescale 1ns/1ps

module dmem_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_err,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t              state, state_next;
    logic                last_b;
    logic                grant_a, grant_b;
    logic                cmd_port;
    logic                cmd_we;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [DATA_W-1:0]   cmd_wdata;
    logic                addr_err;
    logic [DATA_W-1:0]   a_rdata_q, b_rdata_q;
    logic                a_err_q, b_err_q;

    // Grants are gated by reset_n so nothing is granted while reset is held.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state == IDLE && reset_n) begin
            if (a_req && b_req) begin
                grant_a = last_b;
                grant_b = !last_b;
            end else begin
                grant_a = a_req;
                grant_b = b_req;
            end
        end
    end

    assign addr_err = (|cmd_addr[2:0]) || (|cmd_addr[ADDR_W-1:DEPTH_LOG2+3]);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_a || grant_b) state_next = ISSUE;
            ISSUE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Command latch, round-robin pointer and per-port response registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_b    <= 1'b1;
            cmd_port  <= 1'b0;
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
            a_err_q   <= 1'b0;
            b_err_q   <= 1'b0;
        end else begin
            if (grant_a || grant_b) begin
                last_b    <= grant_b;
                cmd_port  <= grant_b;
                cmd_we    <= grant_b ? b_we    : a_we;
                cmd_addr  <= grant_b ? b_addr  : a_addr;
                cmd_wdata <= grant_b ? b_wdata : a_wdata;
            end
            if (state == ISSUE) begin
                a_rdata_q <= (!cmd_port && !cmd_we && !addr_err) ? mem_read_data : '0;
                b_rdata_q <= ( cmd_port && !cmd_we && !addr_err) ? mem_read_data : '0;
                a_err_q   <= !cmd_port && addr_err;
                b_err_q   <=  cmd_port && addr_err;
            end else begin
                a_rdata_q <= '0;
                b_rdata_q <= '0;
                a_err_q   <= 1'b0;
                b_err_q   <= 1'b0;
            end
        end
    end

    always_comb begin
        a_gnt          = grant_a;
        b_gnt          = grant_b;
        a_rvalid       = (state == RESP) && !cmd_port;
        b_rvalid       = (state == RESP) &&  cmd_port;
        a_rdata        = a_rdata_q;
        b_rdata        = b_rdata_q;
        a_err          = a_err_q;
        b_err          = b_err_q;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        if (state == ISSUE && !addr_err) begin
            mem_read       = !cmd_we;
            mem_write      = cmd_we;
            mem_address    = cmd_addr;
            mem_write_data = cmd_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 64-word memory behind it.
`timescale 1ns/1ps

module tb_dmem_arbiter;

    logic        clock;
    logic        reset_n;
    logic        a_req, a_we, a_gnt, a_rvalid, a_err;
    logic [63:0] a_addr, a_wdata, a_rdata;
    logic        b_req, b_we, b_gnt, b_rvalid, b_err;
    logic [63:0] b_addr, b_wdata, b_rdata;
    logic        mem_read, mem_write;
    logic [63:0] mem_address, mem_write_data, mem_read_data;

    logic [63:0] mem_model [64];

    int total = 0;
    int bad   = 0;

    dmem_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    always #5 clock = ~clock;

    assign mem_read_data = mem_model[mem_address[8:3]];

    always @(posedge clock) begin
        if (mem_write) mem_model[mem_address[8:3]] <= mem_write_data;
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one complete access on a port, starting and ending at a negedge in IDLE.
    task automatic applyStimulus(input bit port, input bit we, input logic [63:0] addr,
                                 input logic [63:0] wdata, input logic [63:0] exp_rdata,
                                 input bit exp_err);
        if (port) begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
        end else begin
            a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
        end
        #1;
        checkOutput("gnt", port ? b_gnt : a_gnt, 64'd1);
        checkOutput("gnt_other", port ? a_gnt : b_gnt, 64'd0);
        @(posedge clock); #1;
        a_req = 1'b0; b_req = 1'b0;
        @(negedge clock);
        checkOutput("mem_read", mem_read, {63'd0, !we && !exp_err});
        checkOutput("mem_write", mem_write, {63'd0, we && !exp_err});
        if (!exp_err) checkOutput("mem_address", mem_address, addr);
        if (we && !exp_err) checkOutput("mem_write_data", mem_write_data, wdata);
        @(negedge clock);
        checkOutput("rvalid", port ? b_rvalid : a_rvalid, 64'd1);
        checkOutput("rdata", port ? b_rdata : a_rdata, exp_rdata);
        checkOutput("err", port ? b_err : a_err, {63'd0, exp_err});
        checkOutput("rvalid_other", port ? a_rvalid : b_rvalid, 64'd0);
        checkOutput("rdata_other", port ? a_rdata : b_rdata, 64'd0);
        checkOutput("err_other", port ? a_err : b_err, 64'd0);
        @(negedge clock);
        checkOutput("rvalid_drop", port ? b_rvalid : a_rvalid, 64'd0);
        checkOutput("rdata_drop", port ? b_rdata : a_rdata, 64'd0);
    endtask

    task automatic pulseReset();
        reset_n = 1'b0;
        #1;
        checkOutput("reset_gnt", {62'd0, a_gnt, b_gnt}, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        clock = 1'b0; reset_n = 1'b0;
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
        for (int i = 0; i < 64; i++) mem_model[i] = 64'hA5A5_0000 + 64'(i);
        mem_model[1] = 64'h5555;

        // Reset: a pending request must not be granted, nothing is driven
        @(negedge clock);
        a_req = 1'b1;
        #1;
        checkOutput("reset_a_gnt", a_gnt, 64'd0);
        checkOutput("reset_mem_strobes", {62'd0, mem_read, mem_write}, 64'd0);
        checkOutput("reset_mem_address", mem_address, 64'd0);
        checkOutput("reset_rvalid", {62'd0, a_rvalid, b_rvalid}, 64'd0);
        checkOutput("reset_rdata", a_rdata | b_rdata, 64'd0);
        a_req = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // Write then read back, plus misaligned and out-of-range errors
        applyStimulus(1'b0, 1'b1, 64'h10, 64'hDEAD_BEEF, 64'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 64'h10, 64'd0, 64'hDEAD_BEEF, 1'b0);
        applyStimulus(1'b1, 1'b0, 64'h0C, 64'd0, 64'd0, 1'b1);
        applyStimulus(1'b0, 1'b0, 64'h200, 64'd0, 64'd0, 1'b1);
        applyStimulus(1'b1, 1'b1, 64'h8000_0000_0000_0000, 64'h77, 64'd0, 1'b1);
        applyStimulus(1'b1, 1'b0, 64'h1F8, 64'd0, 64'hA5A5_003F, 1'b0);

        // Simultaneous requests after reset alternate A, B, A, B; loser waits
        pulseReset();
        a_we = 0; b_we = 0; a_addr = 64'h10; b_addr = 64'h18;
        for (int i = 0; i < 4; i++) begin
            a_req = 1'b1; b_req = 1'b1;
            #1;
            checkOutput($sformatf("rr_a_gnt_%0d", i), a_gnt, {63'd0, (i % 2) == 0});
            checkOutput($sformatf("rr_b_gnt_%0d", i), b_gnt, {63'd0, (i % 2) == 1});
            @(posedge clock); #1;
            if ((i % 2) == 0) a_req = 1'b0; else b_req = 1'b0;
            @(negedge clock);
            checkOutput($sformatf("rr_wait_issue_%0d", i), {62'd0, a_gnt, b_gnt}, 64'd0);
            @(negedge clock);
            checkOutput($sformatf("rr_wait_resp_%0d", i), {62'd0, a_gnt, b_gnt}, 64'd0);
            checkOutput($sformatf("rr_rvalid_%0d", i), {62'd0, a_rvalid, b_rvalid},
                        ((i % 2) == 0) ? 64'd2 : 64'd1);
            @(negedge clock);
        end
        a_req = 1'b0; b_req = 1'b0;

        // Port A held high: grants every third cycle, port B silent
        a_req = 1'b1; a_we = 1'b0; a_addr = 64'h10;
        for (int i = 0; i < 9; i++) begin
            #1;
            checkOutput($sformatf("held_a_gnt_%0d", i), a_gnt, {63'd0, (i % 3) == 0});
            checkOutput($sformatf("held_b_quiet_%0d", i),
                        {61'd0, b_gnt, b_rvalid, b_err} | b_rdata, 64'd0);
            @(negedge clock);
        end
        a_req = 1'b0;

        // Reset in the middle of a write: no commit, no response
        a_req = 1'b1; a_we = 1'b1; a_addr = 64'h08; a_wdata = 64'h1234;
        #1;
        checkOutput("abort_gnt", a_gnt, 64'd1);
        @(posedge clock); #1;
        a_req = 1'b0;
        @(negedge clock);
        checkOutput("abort_issue_write", mem_write, 64'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("abort_mem_write", mem_write, 64'd0);
        checkOutput("abort_mem_address", mem_address, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        checkOutput("abort_rvalid_0", a_rvalid, 64'd0);
        @(negedge clock);
        checkOutput("abort_rvalid_1", a_rvalid, 64'd0);
        applyStimulus(1'b0, 1'b0, 64'h08, 64'd0, 64'h5555, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
